dbus_handshake: RTL and testbench



---
 rtl/dbus_handshake_pkg.sv | 32 +++
 rtl/dbus_handshake.sv | 135 +++++++++++++
 tb/tb_dbus_handshake.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_handshake_pkg.sv
// Shared types for the data-bus transaction controller: bus request and
// response records, access size encoding and the controller state enum.
package dbus_handshake_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dbus_state_t;

endpackage

// File: rtl/dbus_handshake.sv
// Data-bus transaction controller. Captures one memory-stage request, holds it
// on the bus until data_ok, then offers the response for one cycle (longer if
// the pipeline is held). Flushed requests still complete on the bus but their
// response is dropped. Also counts stalled cycles with a saturating counter.
module dbus_handshake
    import dbus_handshake_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  dbus_req_t        mreq,
    output dbus_resp_t       mresp,
    output dbus_req_t        dreq,
    input  dbus_resp_t       dresp,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt
);

    dbus_state_t      state_r;
    dbus_state_t      state_s;
    dbus_req_t        req_r;
    dbus_req_t        req_s;
    logic [63:0]      data_r;
    logic [63:0]      data_s;
    logic             discard_r;
    logic             discard_s;
    logic [CNT_W-1:0] stall_cnt_r;

    // addr_ok is implied by data_ok, so the bus side never needs it
    logic unused_s;
    assign unused_s = dresp.addr_ok;

    // Next-state logic: request capture, drain-on-flush and result hand-off
    always_comb begin
        state_s   = state_r;
        req_s     = req_r;
        data_s    = data_r;
        discard_s = discard_r;
        case (state_r)
            IDLE: begin
                if (mreq.valid && !flush_i) begin
                    req_s     = mreq;
                    discard_s = 1'b0;
                    state_s   = BUSY;
                end else begin
                    state_s   = IDLE;
                end
            end
            BUSY: begin
                if (dresp.data_ok) begin
                    data_s = dresp.data;
                    if (discard_r || flush_i) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end else if (flush_i) begin
                    // keep the bus request alive until it finishes, then drop it
                    discard_s = 1'b1;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (flush_i) begin
                    state_s = IDLE;
                end else if (!hold_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and transaction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            req_r     <= '0;
            data_r    <= 64'd0;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            req_r     <= req_s;
            data_r    <= data_s;
            discard_r <= discard_s;
        end
    end

    // Bus request, response and stall outputs decoded from the registered state
    always_comb begin
        dreq    = '0;
        mresp   = '0;
        stall_o = 1'b0;
        case (state_r)
            IDLE: begin
                stall_o = mreq.valid && !flush_i;
            end
            BUSY: begin
                dreq       = req_r;
                dreq.valid = 1'b1;
                stall_o    = 1'b1;
            end
            DONE: begin
                mresp.addr_ok = 1'b1;
                mresp.data_ok = 1'b1;
                mresp.data    = data_r;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Saturating count of stalled cycles since reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (stall_o && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dbus_handshake.sv
// Directed bench for dbus_handshake. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge of the same cycle.
// A narrow counter width is used so saturation is reachable quickly.
module tb_dbus_handshake;
    import dbus_handshake_pkg::*;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    dbus_req_t     mreq;
    dbus_resp_t    mresp;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    logic          hold_i;
    logic          flush_i;
    logic          stall_o;
    logic [CW-1:0] stall_cnt;

    int n_pass;
    int n_total;

    dbus_handshake #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mreq      (mreq),
        .mresp     (mresp),
        .dreq      (dreq),
        .dresp     (dresp),
        .hold_i    (hold_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mreq    = '0;
        dresp   = '0;
        hold_i  = 1'b0;
        flush_i = 1'b0;
        tick();
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++; if (dreq !== '0) $display("FAIL reset_dreq got %h exp 0", dreq); else n_pass++;
        n_total++; if (mresp !== '0) $display("FAIL reset_mresp got %h exp 0", mresp); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_o); else n_pass++;
        n_total++; if (stall_cnt !== 4'd0) $display("FAIL reset_cnt got %0d exp 0", stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_load();
        dbus_req_t r;
        do_reset();
        r = '0; r.valid = 1'b1; r.addr = 64'h0000_0000_8000_1000; r.size = MSIZE8; r.strobe = 8'h00;
        mreq = r;
        @(negedge clk);
        n_total++; if (stall_o !== 1'b1) $display("FAIL load_stall_c0 got %b exp 1", stall_o); else n_pass++;
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL load_dvalid_c0 got %b exp 0", dreq.valid); else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'hDEADBEEF_CAFEF00D;
            end else begin
                dresp = '0;
            end
            @(negedge clk);
            n_total++; if (dreq !== r) $display("FAIL load_dreq_c%0d got %h exp %h", c, dreq, r); else n_pass++;
            n_total++; if (stall_o !== 1'b1) $display("FAIL load_stall_c%0d got %b exp 1", c, stall_o); else n_pass++;
            n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL load_early_resp_c%0d got %b exp 0", c, mresp.data_ok); else n_pass++;
        end
        tick();
        dresp = '0; mreq = '0;
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b1) $display("FAIL load_resp_ok got %b exp 1", mresp.data_ok); else n_pass++;
        n_total++; if (mresp.addr_ok !== 1'b1) $display("FAIL load_resp_aok got %b exp 1", mresp.addr_ok); else n_pass++;
        n_total++; if (mresp.data !== 64'hDEADBEEF_CAFEF00D) $display("FAIL load_resp_data got %h exp deadbeefcafef00d", mresp.data); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL load_stall_c4 got %b exp 0", stall_o); else n_pass++;
        n_total++; if (stall_cnt !== 4'd4) $display("FAIL load_cnt got %0d exp 4", stall_cnt); else n_pass++;
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL load_dvalid_done got %b exp 0", dreq.valid); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL load_resp_c5 got %b exp 0", mresp.data_ok); else n_pass++;
    endtask

    task automatic test_store_zero_wait();
        dbus_req_t r;
        do_reset();
        r = '0; r.valid = 1'b1; r.addr = 64'h0000_0000_8000_0008; r.size = MSIZE8;
        r.strobe = 8'hF0; r.data = 64'h11223344_00000000;
        mreq = r;
        @(negedge clk);
        n_total++; if (stall_o !== 1'b1) $display("FAIL store_stall_c0 got %b exp 1", stall_o); else n_pass++;
        tick();
        dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'h0;
        @(negedge clk);
        n_total++; if (dreq !== r) $display("FAIL store_dreq got %h exp %h", dreq, r); else n_pass++;
        n_total++; if (stall_o !== 1'b1) $display("FAIL store_stall_c1 got %b exp 1", stall_o); else n_pass++;
        tick();
        dresp = '0; mreq = '0;
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b1) $display("FAIL store_done got %b exp 1", mresp.data_ok); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL store_stall_c2 got %b exp 0", stall_o); else n_pass++;
        n_total++; if (stall_cnt !== 4'd2) $display("FAIL store_cnt got %0d exp 2", stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_flush_midflight();
        dbus_req_t r;
        do_reset();
        r = '0; r.valid = 1'b1; r.addr = 64'h0000_0000_8000_2000; r.size = MSIZE4; r.strobe = 8'h0F;
        mreq = r;
        for (int c = 1; c <= 4; c++) begin
            tick();
            flush_i = (c == 2);
            if (c == 3) mreq = '0;
            if (c == 4) begin
                dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'h5555_AAAA_5555_AAAA;
            end else begin
                dresp = '0;
            end
            @(negedge clk);
            n_total++; if (dreq !== r) $display("FAIL flush_dreq_c%0d got %h exp %h", c, dreq, r); else n_pass++;
            n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL flush_resp_c%0d got %b exp 0", c, mresp.data_ok); else n_pass++;
        end
        tick();
        dresp = '0;
        @(negedge clk);
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL flush_dvalid_c5 got %b exp 0", dreq.valid); else n_pass++;
        n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL flush_resp_c5 got %b exp 0", mresp.data_ok); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL flush_stall_c5 got %b exp 0", stall_o); else n_pass++;
        n_total++; if (stall_cnt !== 4'd5) $display("FAIL flush_cnt got %0d exp 5", stall_cnt); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL flush_resp_c6 got %b exp 0", mresp.data_ok); else n_pass++;
    endtask

    task automatic test_flush_with_data_ok();
        do_reset();
        mreq = '0; mreq.valid = 1'b1; mreq.addr = 64'h0000_0000_8000_3000; mreq.size = MSIZE2;
        tick();
        flush_i = 1'b1; dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'h1;
        mreq = '0;
        tick();
        flush_i = 1'b0; dresp = '0;
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL flushok_resp got %b exp 0", mresp.data_ok); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL flushok_stall got %b exp 0", stall_o); else n_pass++;
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL flushok_dvalid got %b exp 0", dreq.valid); else n_pass++;
        tick();
    endtask

    task automatic test_hold_in_done();
        do_reset();
        mreq = '0; mreq.valid = 1'b1; mreq.addr = 64'h0000_0000_8000_4000; mreq.size = MSIZE8;
        tick();
        dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'h0123_4567_89AB_CDEF;
        for (int c = 2; c <= 5; c++) begin
            tick();
            mreq = '0;
            // bus data changing must not disturb the held result
            dresp.data_ok = 1'b0; dresp.addr_ok = 1'b0; dresp.data = 64'hFFFF_0000_FFFF_0000 + 64'(c);
            hold_i = (c <= 4);
            @(negedge clk);
            n_total++; if (mresp.data_ok !== 1'b1) $display("FAIL hold_resp_c%0d got %b exp 1", c, mresp.data_ok); else n_pass++;
            n_total++; if (mresp.data !== 64'h0123_4567_89AB_CDEF) $display("FAIL hold_data_c%0d got %h exp 0123456789abcdef", c, mresp.data); else n_pass++;
            n_total++; if (stall_o !== 1'b0) $display("FAIL hold_stall_c%0d got %b exp 0", c, stall_o); else n_pass++;
        end
        tick();
        hold_i = 1'b0;
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL hold_release got %b exp 0", mresp.data_ok); else n_pass++;
        // flush must override hold while the result is pending
        mreq.valid = 1'b1; mreq.addr = 64'h0000_0000_8000_4008; mreq.size = MSIZE8;
        tick();
        dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'h42;
        tick();
        mreq = '0; dresp = '0; hold_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b1) $display("FAIL holdflush_done got %b exp 1", mresp.data_ok); else n_pass++;
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        n_total++; if (mresp.data_ok !== 1'b0) $display("FAIL holdflush_idle got %b exp 0", mresp.data_ok); else n_pass++;
        hold_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        dbus_req_t ra;
        dbus_req_t rb;
        do_reset();
        ra = '0; ra.valid = 1'b1; ra.addr = 64'h0000_0000_8000_5000; ra.size = MSIZE4; ra.strobe = 8'h00;
        rb = '0; rb.valid = 1'b1; rb.addr = 64'h0000_0000_8000_5010; rb.size = MSIZE1; rb.strobe = 8'h00;
        mreq = ra;
        tick();
        dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'hAAAA;
        @(negedge clk);
        n_total++; if (dreq !== ra) $display("FAIL b2b_dreq_a got %h exp %h", dreq, ra); else n_pass++;
        tick();
        dresp = '0; mreq = rb;
        @(negedge clk);
        n_total++; if (mresp.data !== 64'hAAAA || mresp.data_ok !== 1'b1) $display("FAIL b2b_resp_a got %b/%h exp 1/aaaa", mresp.data_ok, mresp.data); else n_pass++;
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL b2b_dvalid_done_a got %b exp 0", dreq.valid); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (stall_o !== 1'b1) $display("FAIL b2b_stall_idle got %b exp 1", stall_o); else n_pass++;
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL b2b_dvalid_idle got %b exp 0", dreq.valid); else n_pass++;
        tick();
        dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'hBBBB;
        @(negedge clk);
        n_total++; if (dreq !== rb) $display("FAIL b2b_dreq_b got %h exp %h", dreq, rb); else n_pass++;
        tick();
        dresp = '0; mreq = '0;
        @(negedge clk);
        n_total++; if (mresp.data !== 64'hBBBB || mresp.data_ok !== 1'b1) $display("FAIL b2b_resp_b got %b/%h exp 1/bbbb", mresp.data_ok, mresp.data); else n_pass++;
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL b2b_dvalid_done_b got %b exp 0", dreq.valid); else n_pass++;
        n_total++; if (stall_cnt !== 4'd4) $display("FAIL b2b_cnt got %0d exp 4", stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_counter_saturation();
        do_reset();
        mreq = '0; mreq.valid = 1'b1; mreq.addr = 64'h0000_0000_8000_6000; mreq.size = MSIZE8;
        // 20 stalled cycles into a 4-bit counter
        for (int c = 1; c <= 19; c++) begin
            tick();
        end
        dresp.data_ok = 1'b1; dresp.addr_ok = 1'b1; dresp.data = 64'h7;
        @(negedge clk);
        n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat_cnt got %0d exp 15", stall_cnt); else n_pass++;
        tick();
        dresp = '0; mreq = '0;
        @(negedge clk);
        n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat_hold got %0d exp 15", stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_reset_busy();
        do_reset();
        mreq = '0; mreq.valid = 1'b1; mreq.addr = 64'h0000_0000_8000_7000; mreq.size = MSIZE8;
        tick();
        tick();
        reset = 1'b1; mreq = '0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (dreq.valid !== 1'b0) $display("FAIL rstbusy_dvalid got %b exp 0", dreq.valid); else n_pass++;
        n_total++; if (stall_o !== 1'b0) $display("FAIL rstbusy_stall got %b exp 0", stall_o); else n_pass++;
        n_total++; if (stall_cnt !== 4'd0) $display("FAIL rstbusy_cnt got %0d exp 0", stall_cnt); else n_pass++;
        n_total++; if (mresp !== '0) $display("FAIL rstbusy_mresp got %h exp 0", mresp); else n_pass++;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        mreq    = '0;
        dresp   = '0;
        hold_i  = 1'b0;
        flush_i = 1'b0;
        test_reset();
        test_load();
        test_store_zero_wait();
        test_flush_midflight();
        test_flush_with_data_ok();
        test_hold_in_done();
        test_back_to_back();
        test_counter_saturation();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
